// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: round-robin arbiter sharing one variable-latency memory between fetch and data ports
module unified_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              global_en,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              err
);
   typedef enum logic [2:0] {IDLE, REQ_D, WAIT_D, REQ_I, WAIT_I, ERR} state_t;
   state_t            state_q, state_d;
   logic              last_gnt_d_q, last_gnt_d_d;
   logic [15:0]       wd_q, wd_d;
   logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
   logic              i_done_q, i_done_d, d_done_q, d_done_d, err_q, err_d;
   logic              arb, pick_i, busy, finish;

   // arbitration, handshake sequencing and watchdog; arbitration is held off during a done cycle
   always_comb begin
      state_d      = state_q;
      last_gnt_d_d = last_gnt_d_q;
      wd_d         = wd_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      err_d        = err_q;
      i_done_d     = 1'b0;
      d_done_d     = 1'b0;
      arb          = global_en && !i_done_q && !d_done_q && (i_req || d_req);
      pick_i       = i_req && (!d_req || last_gnt_d_q);
      busy         = state_q inside {REQ_D, WAIT_D, REQ_I, WAIT_I};
      finish       = (state_q == WAIT_D || state_q == WAIT_I) && mem_rvalid;
      case (state_q)
         IDLE: if (arb) begin
            state_d      = pick_i ? REQ_I : REQ_D;
            mem_req_d    = 1'b1;
            mem_we_d     = pick_i ? 1'b0 : d_we;
            mem_addr_d   = pick_i ? i_addr : d_addr;
            mem_wdata_d  = pick_i ? mem_wdata_q : d_wdata;
            last_gnt_d_d = !pick_i;
            wd_d         = '0;
         end
         REQ_D: if (mem_gnt) begin
            state_d   = WAIT_D;
            mem_req_d = 1'b0;
         end
         REQ_I: if (mem_gnt) begin
            state_d   = WAIT_I;
            mem_req_d = 1'b0;
         end
         WAIT_D: if (mem_rvalid) begin
            state_d   = IDLE;
            d_done_d  = 1'b1;
            d_rdata_d = mem_rdata;
         end
         WAIT_I: if (mem_rvalid) begin
            state_d   = IDLE;
            i_done_d  = 1'b1;
            i_rdata_d = mem_rdata;
         end
         default: ;
      endcase
      if (busy && !finish) begin
         wd_d = wd_q + 16'd1;
         if (wd_d == 16'(TIMEOUT)) begin
            state_d   = ERR;
            mem_req_d = 1'b0;
            err_d     = 1'b1;
         end
      end
   end

   // state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_gnt_d_q <= 1'b0;
         wd_q         <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         i_done_q     <= 1'b0;
         d_done_q     <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_gnt_d_q <= last_gnt_d_d;
         wd_q         <= wd_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         i_done_q     <= i_done_d;
         d_done_q     <= d_done_d;
         err_q        <= err_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign i_done    = i_done_q;
   assign d_done    = d_done_q;
   assign err       = err_q;
   assign stall_if  = i_req & ~i_done_q;
   assign stall_mem = d_req & ~d_done_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: randomized scoreboard bench for the two-port unified memory arbiter
`timescale 1ns/1ps
module tb_unified_mem_arbiter;
   localparam int AW = 32, DW = 32, TO = 8;
   logic clk = 1'b0, rst = 1'b1, global_en = 1'b0;
   logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [AW-1:0] i_addr = '0, d_addr = '0;
   logic [DW-1:0] d_wdata = '0, i_rdata, d_rdata;
   logic i_done, d_done, mem_req, mem_we, stall_if, stall_mem, err;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   int vectors = 0, miscompares = 0;

   unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .global_en(global_en),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem), .err(err));

   always #5 clk = ~clk;

   logic [DW-1:0] mem [logic [AW-1:0]];
   logic [DW-1:0] ref_mem [logic [AW-1:0]];
   logic [DW:0] iq[$], dq[$];
   int grant_log[$];

   function automatic logic [DW-1:0] hash(input logic [AW-1:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction
   function automatic logic [DW-1:0] mem_get(input logic [AW-1:0] a);
      return mem.exists(a) ? mem[a] : hash(a);
   endfunction
   function automatic logic [DW-1:0] ref_get(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : hash(a);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   // memory responder: random gnt/rvalid latency, spurious strobes that must be ignored
   int gnt_dly = 0, rv_dly = 0;
   bit outstanding = 0, hang = 0, zero_wait = 0;
   logic [AW-1:0] o_addr;
   logic o_we;
   initial forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (outstanding) begin
         if (hang) ;
         else if (rv_dly == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata = o_we ? DW'($urandom) : mem_get(o_addr);
            outstanding = 0;
         end else rv_dly--;
      end else if (mem_req) begin
         if ($urandom_range(0, 3) == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata = DW'($urandom);
         end
         if (gnt_dly == 0) begin
            mem_gnt = 1'b1;
            outstanding = 1;
            o_addr = mem_addr;
            o_we = mem_we;
            if (mem_we) mem[mem_addr] = mem_wdata;
            rv_dly = zero_wait ? 0 : int'($urandom_range(0, 2));
            gnt_dly = zero_wait ? 0 : int'($urandom_range(0, 2));
         end else gnt_dly--;
      end else begin
         if ($urandom_range(0, 7) == 0) mem_gnt = 1'b1;
         if ($urandom_range(0, 7) == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata = DW'($urandom);
         end
      end
   end

   // what the DUT saw at each edge
   logic req_i_e = 0, req_d_e = 0, en_e = 0, rst_e = 1;
   always @(posedge clk) begin
      req_i_e <= i_req;
      req_d_e <= d_req;
      en_e <= global_en;
      rst_e <= rst;
   end

   // monitor: scoreboard pops on done, round-robin grant model, field stability, stalls
   logic [DW-1:0] last_i = '0, last_d = '0, lat_wdata;
   logic [AW-1:0] lat_addr;
   logic lat_we;
   bit prev_mreq = 0, last_was_d = 0, prev_idone = 0, prev_ddone = 0, expect_err = 0;
   initial forever begin
      logic [DW:0] e;
      bit pick_d;
      @(negedge clk);
      #1;
      if (rst_e) begin
         check("rst_mem_req", mem_req, 0);
         check("rst_i_done", i_done, 0);
         check("rst_d_done", d_done, 0);
         check("rst_err", err, 0);
         check("rst_i_rdata", i_rdata, 0);
         check("rst_d_rdata", d_rdata, 0);
         last_i = '0;
         last_d = '0;
         prev_mreq = 0;
         last_was_d = 0;
         prev_idone = 0;
         prev_ddone = 0;
      end else begin
         check("stall_if", stall_if, i_req & ~i_done);
         check("stall_mem", stall_mem, d_req & ~d_done);
         if (!expect_err) check("err_low", err, 0);
         if (i_done) begin
            check("i_done_pulse", prev_idone, 0);
            if (iq.size() == 0) fail("i_done_unexpected");
            else begin
               e = iq.pop_front();
               check("i_rdata", i_rdata, e[DW-1:0]);
            end
            last_i = i_rdata;
         end else check("i_rdata_hold", i_rdata, last_i);
         if (d_done) begin
            check("d_done_pulse", prev_ddone, 0);
            if (dq.size() == 0) fail("d_done_unexpected");
            else begin
               e = dq.pop_front();
               if (!e[DW]) check("d_rdata", d_rdata, e[DW-1:0]);
            end
            last_d = d_rdata;
         end else check("d_rdata_hold", d_rdata, last_d);
         if (mem_req && !prev_mreq) begin
            pick_d = req_d_e && (!req_i_e || !last_was_d);
            check("grant_enabled", en_e, 1);
            check("grant_has_req", req_i_e | req_d_e, 1);
            check("grant_addr", mem_addr, pick_d ? d_addr : i_addr);
            check("grant_we", mem_we, pick_d ? d_we : 1'b0);
            if (pick_d && d_we) check("grant_wdata", mem_wdata, d_wdata);
            grant_log.push_back(int'(pick_d));
            last_was_d = pick_d;
            lat_addr = mem_addr;
            lat_we = mem_we;
            lat_wdata = mem_wdata;
         end else if (mem_req) begin
            check("hold_addr", mem_addr, lat_addr);
            check("hold_we", mem_we, lat_we);
            check("hold_wdata", mem_wdata, lat_wdata);
         end
         prev_mreq = mem_req;
         prev_idone = i_done;
         prev_ddone = d_done;
      end
   end

   task automatic wait_done(input bit port_d, output int lat);
      lat = -1;
      for (int c = 1; c <= 60; c++) begin
         tick();
         if (port_d ? d_done : i_done) begin
            lat = c;
            break;
         end
      end
      if (lat < 0) fail(port_d ? "d_done_timeout" : "i_done_timeout");
   endtask

   task automatic do_fetch(input logic [AW-1:0] a, output int lat);
      iq.push_back({1'b0, ref_get(a)});
      i_addr = a;
      i_req = 1'b1;
      wait_done(1'b0, lat);
      i_req = 1'b0;
   endtask

   task automatic do_data(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd, output int lat);
      if (we) begin
         dq.push_back({1'b1, DW'(0)});
         ref_mem[a] = wd;
      end else dq.push_back({1'b0, ref_get(a)});
      d_we = we;
      d_addr = a;
      d_wdata = wd;
      d_req = 1'b1;
      wait_done(1'b1, lat);
      d_req = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, k;
      bit stop;
      mem[32'h40] = 32'h0010_0093;
      ref_mem[32'h40] = 32'h0010_0093;
      tick();
      tick();
      zero_wait = 1;
      global_en = 1'b1;
      grant_log.delete();
      rst = 1'b0;
      fork
         begin
            int l;
            for (int j = 0; j < 2; j++) do_fetch(32'h10 + 32'(j * 4), l);
         end
         begin
            int l;
            for (int j = 0; j < 2; j++) do_data(1'b0, 32'h2000 + 32'(j * 4), '0, l);
         end
      join
      for (int j = 0; j < 4; j++) check("rr_order", (j < grant_log.size()) ? grant_log[j] : -1, (j % 2 == 0) ? 1 : 0);

      tick();
      gnt_dly = 0;
      do_fetch(32'h40, n);
      check("fetch_latency", n, 3);

      tick();
      gnt_dly = 3;
      do_data(1'b1, 32'h2004, 32'hDEAD_BEEF, n);
      check("store_latency", n, 6);

      tick();
      global_en = 1'b0;
      iq.push_back({1'b0, ref_get(32'h44)});
      i_addr = 32'h44;
      i_req = 1'b1;
      repeat (5) begin
         tick();
         check("en_block", mem_req, 0);
      end
      global_en = 1'b1;
      tick();
      check("en_resume", mem_req, 1);
      wait_done(1'b0, n);
      i_req = 1'b0;

      tick();
      dq.push_back({1'b0, ref_get(32'h2004)});
      d_we = 1'b0;
      d_addr = 32'h2004;
      d_req = 1'b1;
      tick();
      check("inflight_req", mem_req, 1);
      global_en = 1'b0;
      wait_done(1'b1, n);
      d_req = 1'b0;
      check("inflight_done", n > 0, 1);
      global_en = 1'b1;

      zero_wait = 0;
      stop = 0;
      fork
         begin
            fork
               begin
                  int l;
                  for (int j = 0; j < 40; j++) begin
                     repeat ($urandom_range(0, 3)) tick();
                     do_fetch(32'($urandom_range(0, 63)) << 2, l);
                  end
               end
               begin
                  int l;
                  for (int j = 0; j < 40; j++) begin
                     repeat ($urandom_range(0, 3)) tick();
                     do_data(1'($urandom_range(0, 1)), 32'h2000 + (32'($urandom_range(0, 15)) << 2), DW'($urandom), l);
                  end
               end
            join
            stop = 1;
         end
         begin
            while (!stop) begin
               tick();
               global_en = ($urandom_range(0, 3) != 0);
            end
         end
      join
      global_en = 1'b1;
      check("iq_drained", iq.size(), 0);
      check("dq_drained", dq.size(), 0);

      zero_wait = 1;
      tick();
      hang = 1;
      d_we = 1'b0;
      d_addr = 32'h2010;
      d_req = 1'b1;
      k = 0;
      while (!mem_req && k < 20) begin tick(); k++; end
      while (mem_req && k < 40) begin tick(); k++; end
      check("rw_in_wait", k < 40, 1);
      rst = 1'b1;
      d_req = 1'b0;
      tick();
      rst = 1'b0;
      hang = 0;
      rv_dly = 0;
      repeat (4) begin
         tick();
         check("rw_no_done", d_done, 0);
         check("rw_rdata", d_rdata, 0);
         check("rw_mem_req", mem_req, 0);
      end
      gnt_dly = 0;
      do_fetch(32'h48, n);
      check("rw_idle_fetch", n, 3);

      tick();
      hang = 1;
      expect_err = 1;
      gnt_dly = 0;
      i_addr = 32'h80;
      i_req = 1'b1;
      k = 0;
      while (!mem_req && k < 20) begin tick(); k++; end
      k = 0;
      while (!err && k < 30) begin
         tick();
         k++;
      end
      check("to_cycles", k, TO);
      check("to_mem_req", mem_req, 0);
      repeat (3) begin
         tick();
         check("to_err_sticky", err, 1);
         check("to_no_req", mem_req, 0);
         check("to_no_done", i_done, 0);
      end
      i_req = 1'b0;
      hang = 0;
      outstanding = 0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      expect_err = 0;
      do_fetch(32'h84, n);
      check("to_recover_fetch", n, 3);
      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between two requesters: the instruction-fetch port (IF stage) and the data port (MEM stage).
- Sequences each transfer with a req/gnt/rvalid handshake toward memory.
- Returns read data and a one-cycle done pulse to the requester, and drives per-stage stall lines into the pipeline hazard logic.
- Uses round-robin fairness when both ports request together, and a watchdog timeout that latches a sticky error.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, max cycles a transfer may spend in REQ+WAIT before error; range 1..(2^16-1).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- global_en  in  1  arbitration enable; low blocks new grants, in-flight transfer still completes.
- i_req  in  1  fetch request; held high until i_done.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetch data, registered.
- i_done  out  1  one-cycle pulse, i_rdata valid.
- d_req  in  1  data request; held high until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, registered.
- d_done  out  1  one-cycle pulse, d_rdata valid / store accepted.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_gnt  in  1  memory accepts request this cycle.
- mem_rvalid  in  1  response for the accepted request; sent for both reads and writes.
- mem_rdata  in  DATA_W  read data, valid with mem_rvalid.
- stall_if  out  1  = i_req & ~i_done, combinational.
- stall_mem  out  1  = d_req & ~d_done, combinational.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset values: state IDLE; i_rdata, d_rdata, mem_addr, mem_wdata = 0; mem_req, mem_we, i_done, d_done, err = 0; last_gnt_d = 0; watchdog = 0.
- States: IDLE, REQ_D, WAIT_D, REQ_I, WAIT_I, ERR.
- IDLE, global_en=1:
  - Only d_req → REQ_D.
  - Only i_req → REQ_I.
  - Both → grant I if last_gnt_d=1, else D.
  - On grant: latch addr/we/wdata into mem_* registers; set last_gnt_d accordingly; clear watchdog.
  - A fetch grant forces mem_we=0.
- IDLE, global_en=0: no state change; mem_req stays 0.
- REQ_x: mem_req=1 with latched fields. On mem_gnt → WAIT_x with mem_req=0 the next cycle. Latched fields stay stable while mem_req=1, even if requester inputs change.
- WAIT_x: on mem_rvalid, capture mem_rdata into x_rdata (d_rdata also captured for stores, value don't-care), pulse x_done for exactly one cycle, go IDLE. Next arbitration happens the cycle after done. Minimum turnaround: grant → done = 2 cycles with zero-wait memory (REQ, gnt; WAIT, rvalid; done registered at the next edge).
- mem_rvalid outside WAIT_x is ignored.
- mem_gnt outside REQ_x is ignored.
- Watchdog: increments each cycle in REQ_x/WAIT_x. When it reaches TIMEOUT without completion → ERR; err=1, mem_req=0, no done pulse. ERR is exited only by rst.
- Simultaneous mem_gnt and mem_rvalid in REQ_x: take gnt only; rvalid is ignored.
- rst mid-transfer: drop to IDLE the same edge; mem_req low the next cycle; a late mem_rvalid is ignored; no done pulse.
- rdata outputs hold their value until the next done on the same port.
- Requesters hold req high until done; the arbiter does not require req to stay high after grant.

Test Plan:
- Single fetch, i_addr=0x0000_0040, memory gnt same cycle, rvalid 1 cycle later with 0x0010_0093 → i_rdata=0x0010_0093, i_done one cycle, stall_if low the cycle i_done is high, mem_we=0 throughout.
- Store d_we=1, d_addr=0x0000_2004, d_wdata=0xDEAD_BEEF, gnt delayed 3 cycles → mem_addr/mem_wdata stable all 3 cycles, d_done one pulse after rvalid, stall_mem high until then.
- i_req and d_req both high from reset for 4 transfers → grant order D, I, D, I; no starvation; each done exactly once per transfer.
- TIMEOUT=8, gnt given, rvalid never asserted → err=1 exactly 8 cycles after the grant cycle, mem_req=0, no done, stays ERR until rst; after rst err=0 and a new fetch completes.
- rst asserted in WAIT_D, rvalid arrives 1 cycle after rst deasserts → no d_done, d_rdata=0, state IDLE.
- global_en=0 with i_req=1 → mem_req stays 0 for 5 cycles; global_en=1 → REQ_I the next edge. Transfer in flight when global_en drops → still completes with done.
